sr_reg_bank: RTL and testbench



---
 rtl/sr_reg_bank_pkg.sv | 21 ++
 rtl/sr_reg_chan.sv | 119 +++++++++++
 rtl/sr_reg_bank.sv | 58 +++++
 tb/tb_sr_reg_bank.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_reg_bank_pkg.sv
// sr_reg_bank_pkg
// Shared types and helpers for the set/reset register bank.
//   act_e     : per-channel action decoded each edge, highest priority first
//   cnt_width : recovery counter width, at least one bit
package sr_reg_bank_pkg;

    typedef enum logic [2:0] {
        ACT_SET,
        ACT_RST,
        ACT_LOAD,
        ACT_BLOCK,
        ACT_HOLD
    } act_e;

    function automatic int cnt_width(input int recov);
        int w;
        w = $clog2(recov + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/sr_reg_chan.sv
// sr_reg_chan
// One channel of the register bank: WIDTH storage bits, a recovery
// down-counter that blocks loads after set/reset release, and a sticky
// violation flag for loads attempted while busy.
// Ports:
//   clk_i       clock, rising edge
//   rst_i       synchronous active-high reset
//   d_i         load data
//   en_i        load enable
//   setb_i      synchronous set to SET_VAL, active-low (wins over rstb_i)
//   rstb_i      synchronous clear, active-low
//   viol_clr_i  clears viol_o unless a new violation happens on that edge
//   qn_o        stored value, inverted when OUT_INV=1
//   busy_o      set/reset active or recovery window running
//   viol_o      sticky flag, load attempted while busy
module sr_reg_chan
    import sr_reg_bank_pkg::*;
#(
    parameter int               WIDTH   = 8,
    parameter int               RECOV   = 2,
    parameter bit               OUT_INV = 1'b1,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    input  logic             en_i,
    input  logic             setb_i,
    input  logic             rstb_i,
    input  logic             viol_clr_i,
    output logic [WIDTH-1:0] qn_o,
    output logic             busy_o,
    output logic             viol_o
);

    localparam int            CW         = cnt_width(RECOV);
    localparam logic [CW-1:0] CNT_RELOAD = CW'(RECOV);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [WIDTH-1:0] q_q, q_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             viol_q, viol_d;
    logic             cnt_zero;
    act_e             act;

    assign cnt_zero = (cnt_q == '0);

    always_comb begin
        act = ACT_HOLD;
        if (!setb_i) begin
            act = ACT_SET;
        end else if (!rstb_i) begin
            act = ACT_RST;
        end else if (en_i && cnt_zero) begin
            act = ACT_LOAD;
        end else if (en_i) begin
            act = ACT_BLOCK;
        end
    end

    always_comb begin
        q_d    = q_q;
        cnt_d  = cnt_q;
        viol_d = viol_q;
        // A clear request loses to a violation on the same edge; ACT_BLOCK
        // overrides this below.
        if (viol_clr_i) begin
            viol_d = 1'b0;
        end
        case (act)
            ACT_SET: begin
                q_d   = SET_VAL;
                cnt_d = CNT_RELOAD;
            end
            ACT_RST: begin
                q_d   = '0;
                cnt_d = CNT_RELOAD;
            end
            ACT_LOAD: begin
                q_d = d_i;
            end
            ACT_BLOCK: begin
                viol_d = 1'b1;
                cnt_d  = cnt_q - CNT_ONE;
            end
            default: begin
                if (!cnt_zero) begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            q_q    <= '0;
            cnt_q  <= '0;
            viol_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            cnt_q  <= cnt_d;
            viol_q <= viol_d;
        end
    end

    // Busy includes the live set/reset inputs so a load on the same edge
    // is already reported as not accepted.
    assign busy_o = !cnt_zero || !setb_i || !rstb_i;
    assign viol_o = viol_q;

    generate
        if (OUT_INV) begin : g_inv
            assign qn_o = ~q_q;
        end else begin : g_true
            assign qn_o = q_q;
        end
    endgenerate

endmodule

// File: rtl/sr_reg_bank.sv
// sr_reg_bank
// NCH independent set/reset register channels with load enable, recovery
// hold-off after set/reset release and sticky violation flags.
// Ports:
//   CLK       clock, rising edge
//   RST       synchronous active-high reset, overrides all inputs
//   D         load data, channel c at [c*WIDTH +: WIDTH]
//   EN        per-channel load enable
//   SETB      per-channel synchronous set, active-low
//   RSTB      per-channel synchronous clear, active-low
//   VIOL_CLR  per-channel clear of the sticky violation flag
//   QN        stored values, polarity per OUT_INV
//   BUSY      per-channel busy, loads not accepted
//   VIOL      per-channel sticky violation flag
module sr_reg_bank
    import sr_reg_bank_pkg::*;
#(
    parameter int               NCH     = 4,
    parameter int               WIDTH   = 8,
    parameter int               RECOV   = 2,
    parameter bit               OUT_INV = 1'b1,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NCH*WIDTH-1:0] D,
    input  logic [NCH-1:0]       EN,
    input  logic [NCH-1:0]       SETB,
    input  logic [NCH-1:0]       RSTB,
    input  logic [NCH-1:0]       VIOL_CLR,
    output logic [NCH*WIDTH-1:0] QN,
    output logic [NCH-1:0]       BUSY,
    output logic [NCH-1:0]       VIOL
);

    generate
        for (genvar c = 0; c < NCH; c++) begin : g_chan
            sr_reg_chan #(
                .WIDTH   (WIDTH),
                .RECOV   (RECOV),
                .OUT_INV (OUT_INV),
                .SET_VAL (SET_VAL)
            ) u_chan (
                .clk_i      (CLK),
                .rst_i      (RST),
                .d_i        (D[c*WIDTH +: WIDTH]),
                .en_i       (EN[c]),
                .setb_i     (SETB[c]),
                .rstb_i     (RSTB[c]),
                .viol_clr_i (VIOL_CLR[c]),
                .qn_o       (QN[c*WIDTH +: WIDTH]),
                .busy_o     (BUSY[c]),
                .viol_o     (VIOL[c])
            );
        end
    endgenerate

endmodule

// File: tb/tb_sr_reg_bank.sv
// tb_sr_reg_bank
// Two instances: the default bank (4 ch x 8 bit, RECOV=2, inverted QN) and a
// degenerate one (1 ch x 1 bit, RECOV=0, true QN). The model remembers the
// edge index of the last set/reset per channel; a load at edge e is accepted
// when e > last_sr + RECOV. Directed pins hold literal expectations.
module tb_sr_reg_bank;

    localparam int RECOV_A = 2;
    localparam int RECOV_B = 0;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] d;
    logic [3:0]  en, setb, rstb, clr;
    logic [31:0] qn;
    logic [3:0]  busy, viol;

    logic [0:0]  d_b, en_b, setb_b, rstb_b, clr_b;
    logic [0:0]  qn_b, busy_b, viol_b;

    sr_reg_bank dut (
        .CLK(CLK), .RST(RST), .D(d), .EN(en), .SETB(setb), .RSTB(rstb),
        .VIOL_CLR(clr), .QN(qn), .BUSY(busy), .VIOL(viol)
    );

    sr_reg_bank #(
        .NCH(1), .WIDTH(1), .RECOV(RECOV_B), .OUT_INV(1'b0), .SET_VAL(1'b1)
    ) dut_b (
        .CLK(CLK), .RST(RST), .D(d_b), .EN(en_b), .SETB(setb_b), .RSTB(rstb_b),
        .VIOL_CLR(clr_b), .QN(qn_b), .BUSY(busy_b), .VIOL(viol_b)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    // model state
    int         edge_n = 0;
    bit         model_valid = 1'b0;
    logic [7:0] m_q [4];
    int         m_last [4];
    logic       m_viol [4];
    logic       mb_q;
    int         mb_last;
    logic       mb_viol;

    // literal pins for the current cycle
    logic [3:0] pin_v;
    logic [7:0] pin_qn [4];
    logic       pin_busy [4];
    logic       pin_viol [4];
    logic       pinb_v, pinb_qn, pinb_busy, pinb_viol;

    always @(posedge CLK) begin
        edge_n++;
        if (RST) begin
            for (int c = 0; c < 4; c++) begin
                m_q[c] = 8'h00;
                m_last[c] = -1000;
                m_viol[c] = 1'b0;
            end
            mb_q = 1'b0;
            mb_last = -1000;
            mb_viol = 1'b0;
            model_valid = 1'b1;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (!setb[c]) begin
                    m_q[c] = 8'hFF;
                    m_last[c] = edge_n;
                    if (clr[c]) m_viol[c] = 1'b0;
                end else if (!rstb[c]) begin
                    m_q[c] = 8'h00;
                    m_last[c] = edge_n;
                    if (clr[c]) m_viol[c] = 1'b0;
                end else if (en[c] && edge_n <= m_last[c] + RECOV_A) begin
                    m_viol[c] = 1'b1;
                end else begin
                    if (en[c]) m_q[c] = d[c*8 +: 8];
                    if (clr[c]) m_viol[c] = 1'b0;
                end
            end
            if (!setb_b[0]) begin
                mb_q = 1'b1;
                mb_last = edge_n;
                if (clr_b[0]) mb_viol = 1'b0;
            end else if (!rstb_b[0]) begin
                mb_q = 1'b0;
                mb_last = edge_n;
                if (clr_b[0]) mb_viol = 1'b0;
            end else if (en_b[0] && edge_n <= mb_last + RECOV_B) begin
                mb_viol = 1'b1;
            end else begin
                if (en_b[0]) mb_q = d_b[0];
                if (clr_b[0]) mb_viol = 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s ch%0d t=%0t got=%h want=%h", nm, c, $time, act, exp);
        end
    endtask

    always @(negedge CLK) begin
        if (model_valid) begin
            for (int c = 0; c < 4; c++) begin
                logic [7:0] eq;
                logic       eb;
                eq = ~m_q[c];
                eb = !setb[c] || !rstb[c] || ((edge_n + 1) <= m_last[c] + RECOV_A);
                chk("qn", c, qn[c*8 +: 8], eq);
                chk("busy", c, {7'b0, busy[c]}, {7'b0, eb});
                chk("viol", c, {7'b0, viol[c]}, {7'b0, m_viol[c]});
                if (pin_v[c]) begin
                    chk("pin_qn", c, qn[c*8 +: 8], pin_qn[c]);
                    chk("pin_busy", c, {7'b0, busy[c]}, {7'b0, pin_busy[c]});
                    chk("pin_viol", c, {7'b0, viol[c]}, {7'b0, pin_viol[c]});
                end
            end
            begin
                logic ebb;
                ebb = !setb_b[0] || !rstb_b[0] || ((edge_n + 1) <= mb_last + RECOV_B);
                chk("b_qn", 0, {7'b0, qn_b[0]}, {7'b0, mb_q});
                chk("b_busy", 0, {7'b0, busy_b[0]}, {7'b0, ebb});
                chk("b_viol", 0, {7'b0, viol_b[0]}, {7'b0, mb_viol});
            end
            if (pinb_v) begin
                chk("pinb_qn", 0, {7'b0, qn_b[0]}, {7'b0, pinb_qn});
                chk("pinb_busy", 0, {7'b0, busy_b[0]}, {7'b0, pinb_busy});
                chk("pinb_viol", 0, {7'b0, viol_b[0]}, {7'b0, pinb_viol});
            end
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
        pin_v  = 4'b0;
        pinb_v = 1'b0;
    endtask

    task automatic pin(input int c, input logic [7:0] q, input logic b, input logic v);
        pin_v[c]    = 1'b1;
        pin_qn[c]   = q;
        pin_busy[c] = b;
        pin_viol[c] = v;
    endtask

    task automatic pinb(input logic q, input logic b, input logic v);
        pinb_v    = 1'b1;
        pinb_qn   = q;
        pinb_busy = b;
        pinb_viol = v;
    endtask

    initial begin
        pin_v = 4'b0;
        pinb_v = 1'b0;
        RST = 1'b1;
        d = {4{8'hA5}};
        en = 4'hF; setb = 4'hF; rstb = 4'hF; clr = 4'h0;
        d_b = 1'b1; en_b = 1'b1; setb_b = 1'b1; rstb_b = 1'b1; clr_b = 1'b0;
        step();
        step();
        // reset state, RST released with loads pending
        RST = 1'b0;
        for (int c = 0; c < 4; c++) pin(c, 8'hFF, 1'b0, 1'b0);
        pinb(1'b0, 1'b0, 1'b0);
        step();
        for (int c = 0; c < 4; c++) pin(c, 8'h5A, 1'b0, 1'b0);
        pinb(1'b1, 1'b0, 1'b0);
        en = 4'h0;
        en_b = 1'b0;
        // priority: set+reset+load on ch0; set on the 1-bit bank
        setb[0] = 1'b0; rstb[0] = 1'b0; en[0] = 1'b1; d[7:0] = 8'h3C;
        setb_b = 1'b0; d_b = 1'b0;
        pin(0, 8'h5A, 1'b1, 1'b0);
        pinb(1'b1, 1'b1, 1'b0);
        step();
        setb = 4'hF; rstb = 4'hF; en = 4'h0;
        setb_b = 1'b1; en_b = 1'b1;
        pin(0, 8'h00, 1'b1, 1'b0);
        for (int c = 1; c < 4; c++) pin(c, 8'h5A, 1'b0, 1'b0);
        pinb(1'b1, 1'b0, 1'b0);
        step();
        en_b = 1'b0;
        pinb(1'b0, 1'b0, 1'b0);
        step();
        // recovery window on ch1
        rstb[1] = 1'b0;
        step();
        rstb = 4'hF; en[1] = 1'b1; d[15:8] = 8'h11;
        pin(1, 8'hFF, 1'b1, 1'b0);
        step();
        pin(1, 8'hFF, 1'b1, 1'b1);
        step();
        pin(1, 8'hFF, 1'b0, 1'b1);
        step();
        en = 4'h0; clr[1] = 1'b1;
        pin(1, 8'hEE, 1'b0, 1'b1);
        step();
        clr = 4'h0;
        pin(1, 8'hEE, 1'b0, 1'b0);
        step();
        // clear together with a blocked load: set wins
        rstb[1] = 1'b0;
        pin(1, 8'hEE, 1'b1, 1'b0);
        step();
        rstb = 4'hF; en[1] = 1'b1; clr[1] = 1'b1;
        pin(1, 8'hFF, 1'b1, 1'b0);
        step();
        en = 4'h0; clr = 4'h0;
        pin(1, 8'hFF, 1'b1, 1'b1);
        step();
        step();
        step();
        // window restart on ch2
        setb[2] = 1'b0;
        step();
        setb = 4'hF;
        pin(2, 8'h00, 1'b1, 1'b0);
        step();
        setb[2] = 1'b0;
        pin(2, 8'h00, 1'b1, 1'b0);
        step();
        setb = 4'hF; en[2] = 1'b1; d[23:16] = 8'h77;
        pin(2, 8'h00, 1'b1, 1'b0);
        step();
        pin(2, 8'h00, 1'b1, 1'b1);
        step();
        pin(2, 8'h00, 1'b0, 1'b1);
        step();
        en = 4'h0;
        pin(2, 8'h88, 1'b0, 1'b1);
        step();
        // randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            RST = ($urandom_range(0, 99) == 0);
            d = $urandom;
            for (int c = 0; c < 4; c++) begin
                setb[c] = ($urandom_range(0, 9) != 0);
                rstb[c] = ($urandom_range(0, 9) != 0);
                en[c]   = ($urandom_range(0, 1) == 1);
                clr[c]  = ($urandom_range(0, 7) == 0);
            end
            d_b[0]    = ($urandom_range(0, 1) == 1);
            setb_b[0] = ($urandom_range(0, 5) != 0);
            rstb_b[0] = ($urandom_range(0, 5) != 0);
            en_b[0]   = ($urandom_range(0, 1) == 1);
            clr_b[0]  = ($urandom_range(0, 3) == 0);
            step();
        end
        RST = 1'b0;
        en = 4'h0; setb = 4'hF; rstb = 4'hF; clr = 4'h0;
        en_b = 1'b0; setb_b = 1'b1; rstb_b = 1'b1; clr_b = 1'b0;
        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
